rf_subleq_ctrl: RTL and testbench

Sequencer that executes SUBLEQ instructions against the 32x32 register file (`rf_top`), which is instantiated as its sibling. It fetches 18-bit instructions from an external instruction memory over a req/ack handshake. For each instruction it computes `R[b] <= R[b] - R[a]` and branches to `c` when the result is <= 0. While the core is idle or halted, it also arbitrates a host port that loads and inspects registers.

---
 rtl/rf_subleq_pkg.sv | 27 ++
 rtl/rf_subleq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rf_subleq_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_subleq_pkg.sv
// Shared types and constants for the SUBLEQ sequencer: FSM states,
// instruction field layout and the halt address.
package rf_subleq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_READ  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4,
        ST_HOST  = 3'd5
    } state_e;

    // Instruction word: {c[17:10], b[9:5], a[4:0]}
    localparam int INSN_W = 18;
    localparam int REG_AW = 5;
    localparam int C_W    = 8;
    localparam int A_LSB  = 0;
    localparam int B_LSB  = 5;
    localparam int C_LSB  = 10;

    // Reaching this address stops the core.
    function automatic logic [31:0] halt_addr(input int pc_w);
        return (pc_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pc_w) - 32'd1);
    endfunction

endpackage

// File: rtl/rf_subleq_ctrl.sv
// SUBLEQ sequencer driving a sibling 32x32 register file: fetch, read, subtract,
// write back and branch, plus a host port served while the core is idle or halted.
module rf_subleq_ctrl
    import rf_subleq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       insn_count,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic [REG_AW-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_w_ena
);

    localparam logic [PC_W-1:0] HALT_PC = PC_W'(halt_addr(PC_W));

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [REG_AW-1:0]   a_q, a_d;
    logic [REG_AW-1:0]   b_q, b_d;
    logic [C_W-1:0]      c_q, c_d;
    logic                host_we_q, host_we_d;
    logic [REG_AW-1:0]   host_addr_q, host_addr_d;
    logic [DATA_W-1:0]   host_wdata_q, host_wdata_d;

    logic [DATA_W-1:0]   diff;
    logic                leq;
    logic [PC_W-1:0]     seq_pc;
    logic [PC_W-1:0]     next_pc;

    assign diff    = rf_rb_data - rf_ra_data;
    assign leq     = (diff == '0) || diff[DATA_W-1];
    assign seq_pc  = pc_q + PC_W'(1);
    assign next_pc = leq ? PC_W'(c_q) : seq_pc;

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so paths
        // that do not assign it cannot infer a latch.
        state_d      = state_q;
        ret_d        = ret_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        host_we_d    = host_we_q;
        host_addr_d  = host_addr_q;
        host_wdata_d = host_wdata_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end else if (host_req) begin
                    state_d      = ST_HOST;
                    ret_d        = state_q;
                    host_we_d    = host_we;
                    host_addr_d  = host_addr;
                    host_wdata_d = host_wdata;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    a_d     = imem_data[A_LSB +: REG_AW];
                    b_d     = imem_data[B_LSB +: REG_AW];
                    c_d     = imem_data[C_LSB +: C_W];
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                pc_d    = next_pc;
                cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                state_d = (next_pc == HALT_PC) ? ST_HALT : ST_FETCH;
            end
            ST_HOST: state_d = ret_q;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates are non-blocking so every register samples
        // the values from before this edge, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            pc_q         <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            host_we_q    <= 1'b0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            host_we_q    <= host_we_d;
            host_addr_q  <= host_addr_d;
            host_wdata_q <= host_wdata_d;
        end
    end

    assign busy       = (state_q == ST_FETCH) || (state_q == ST_READ) || (state_q == ST_EXEC);
    assign halted     = (state_q == ST_HALT);
    assign pc         = pc_q;
    assign insn_count = cnt_q;
    assign imem_addr  = pc_q;
    // Strobes are masked by rst so a reset landing mid-instruction issues nothing.
    assign imem_req   = (state_q == ST_FETCH) && !rst;
    assign host_ack   = (state_q == ST_HOST) && !rst;

    always_comb begin
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        rf_w_addr  = '0;
        rf_w_data  = '0;
        rf_w_ena   = 1'b0;
        host_rdata = '0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Host read address goes out a cycle early to cover the RF read latency.
                if (host_req) rf_ra_addr = host_addr;
            end
            ST_READ: begin
                rf_ra_addr = a_q;
                rf_rb_addr = b_q;
            end
            ST_EXEC: begin
                rf_ra_addr = a_q;
                rf_rb_addr = b_q;
                rf_w_ena   = 1'b1;
                rf_w_addr  = b_q;
                rf_w_data  = diff;
            end
            ST_HOST: begin
                rf_ra_addr = host_addr_q;
                if (host_we_q) begin
                    rf_w_ena  = 1'b1;
                    rf_w_addr = host_addr_q;
                    rf_w_data = host_wdata_q;
                end else begin
                    host_rdata = rf_ra_data;
                end
            end
            default: ;
        endcase

        if (rst) rf_w_ena = 1'b0;
    end

endmodule

// File: tb/tb_rf_subleq_ctrl.sv
// Self-checking bench for rf_subleq_ctrl with a behavioural register file,
// an instruction memory with configurable wait states and a SUBLEQ reference model.
module tb_rf_subleq_ctrl;

    localparam int PC_W   = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, halted;
    logic [PC_W-1:0]   pc;
    logic [15:0]       insn_count;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [17:0]       imem_data;
    logic              host_req, host_we;
    logic [4:0]        host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic [4:0]        rf_ra_addr, rf_rb_addr, rf_w_addr;
    logic [DATA_W-1:0] rf_ra_data, rf_rb_data, rf_w_data;
    logic              rf_w_ena;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_subleq_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted),
        .pc(pc), .insn_count(insn_count), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_w_addr(rf_w_addr),
        .rf_w_data(rf_w_data), .rf_w_ena(rf_w_ena)
    );

    // Register file stand-in: registered reads, write at the clock edge.
    logic [DATA_W-1:0] rf_mem [32];
    always @(posedge clk) begin
        rf_ra_data <= rf_mem[rf_ra_addr];
        rf_rb_data <= rf_mem[rf_rb_addr];
        if (rf_w_ena) rf_mem[rf_w_addr] <= rf_w_data;
    end

    // Instruction memory with wait states chosen per fetch.
    logic [17:0] imem [256];
    bit          stall_mode = 1'b0;
    logic [7:0]  stall_addr = 8'h00;
    int          rand_wait_max = 0;
    int          wait_cnt = 0;
    int          rnd_wait = 0;
    int          tgt;

    always @(negedge clk) begin
        if (!imem_req) begin
            imem_ack  = 1'b0;
            imem_data = 18'($urandom);
            wait_cnt  = 0;
            rnd_wait  = $urandom_range(0, rand_wait_max);
        end else begin
            tgt = stall_mode ? ((imem_addr == stall_addr) ? 4 : 0) : rnd_wait;
            if (wait_cnt >= tgt) begin
                imem_ack  = 1'b1;
                imem_data = imem[imem_addr];
            end else begin
                imem_ack  = 1'b0;
                imem_data = 18'($urandom);
                wait_cnt++;
            end
        end
    end

    function automatic logic [17:0] mk(input logic [7:0] c, input logic [4:0] b, input logic [4:0] a);
        return {c, b, a};
    endfunction

    task automatic host_op(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        lat = -1; rd = '0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (host_ack === 1'b1) begin
                lat = i;
                rd  = host_rdata;
                break;
            end
        end
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            if (halted === 1'b1) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, halted, imem_req, host_ack, rf_w_ena} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 00000", {busy, halted, imem_req, host_ack, rf_w_ena});
        end
        checks++;
        if ({pc, insn_count, imem_addr} !== '0) begin
            errors++; $display("FAIL reset_counters pc=%h cnt=%h addr=%h want 0", pc, insn_count, imem_addr);
        end
        checks++;
        if ({rf_ra_addr, rf_rb_addr, rf_w_addr, rf_w_data, host_rdata} !== '0) begin
            errors++; $display("FAIL reset_buses ra=%h rb=%h wa=%h wd=%h hr=%h want 0",
                               rf_ra_addr, rf_rb_addr, rf_w_addr, rf_w_data, host_rdata);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        int lat, n;
        host_op(1'b1, 5'd1, 32'd5, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL basic_host_lat got %0d want 1", lat); end
        host_op(1'b1, 5'd2, 32'd3, rd, lat);
        host_op(1'b0, 5'd1, 32'd0, rd, lat);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL basic_readback got %h want 5", rd); end
        imem[0]    = mk(8'h10, 5'd2, 5'd1);
        imem[8'h10] = mk(8'hFF, 5'd0, 5'd0);
        do_start();
        checks++; if (busy !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL basic_fetch busy=%b pc=%h want 1/00", busy, pc); end
        repeat (2) @(negedge clk);
        checks++;
        if (rf_w_ena !== 1'b1 || rf_w_addr !== 5'd2 || rf_w_data !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL basic_exec_write ena=%b addr=%h data=%h want 1/02/fffffffe", rf_w_ena, rf_w_addr, rf_w_data);
        end
        @(negedge clk);
        checks++;
        if (pc !== 8'h10 || insn_count !== 16'd1) begin
            errors++; $display("FAIL basic_branch pc=%h cnt=%0d want 10/1", pc, insn_count);
        end
        wait_halted(50, n);
        checks++; if (n < 0) begin errors++; $display("FAIL basic_halt_timeout halted=%b want 1", halted); end
        host_op(1'b0, 5'd2, 32'd0, rd, lat);
        checks++; if (rd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL basic_r2 got %h want fffffffe", rd); end
    endtask

    task automatic test_no_branch();
        logic [31:0] rd;
        int lat, n;
        host_op(1'b1, 5'd1, 32'd1, rd, lat);
        host_op(1'b1, 5'd2, 32'd10, rd, lat);
        imem[0] = mk(8'h20, 5'd2, 5'd1);
        imem[1] = mk(8'hFF, 5'd0, 5'd0);
        do_start();
        repeat (2) @(negedge clk);
        checks++; if (rf_w_data !== 32'd9) begin errors++; $display("FAIL nobr_wdata got %h want 9", rf_w_data); end
        @(negedge clk);
        checks++;
        if (pc !== 8'h01 || insn_count !== 16'd1) begin
            errors++; $display("FAIL nobr_pc pc=%h cnt=%0d want 01/1", pc, insn_count);
        end
        wait_halted(50, n);
        checks++;
        if (n < 0 || pc !== 8'hFF || insn_count !== 16'd2) begin
            errors++; $display("FAIL nobr_halt n=%0d pc=%h cnt=%0d want halted/ff/2", n, pc, insn_count);
        end
        host_op(1'b0, 5'd2, 32'd0, rd, lat);
        checks++; if (rd !== 32'd9) begin errors++; $display("FAIL nobr_r2 got %h want 9", rd); end
    endtask

    task automatic test_halt();
        logic [31:0] rd;
        int lat;
        host_op(1'b1, 5'd3, 32'h1234_5678, rd, lat);
        imem[0] = mk(8'hFF, 5'd3, 5'd3);
        do_start();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_exec busy=%b halted=%b want 1/0", busy, halted); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b1 || pc !== 8'hFF || insn_count !== 16'd1) begin
            errors++; $display("FAIL halt_state busy=%b halted=%b pc=%h cnt=%0d want 0/1/ff/1", busy, halted, pc, insn_count);
        end
        host_op(1'b0, 5'd3, 32'd0, rd, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL halt_r3 got %h want 0", rd); end
    endtask

    task automatic test_fetch_stall();
        int n;
        stall_mode = 1'b1; stall_addr = 8'h30;
        imem[0]    = mk(8'h30, 5'd0, 5'd0);
        imem[8'h30] = mk(8'hFF, 5'd0, 5'd0);
        do_start();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h30 || rf_w_ena !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_cyc%0d req=%b addr=%h wena=%b busy=%b want 1/30/0/1", i, imem_req, imem_addr, rf_w_ena, busy);
            end
            @(negedge clk);
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_ack_cycle req=%b want 1", imem_req); end
        repeat (2) @(negedge clk);
        checks++; if (rf_w_ena !== 1'b1) begin errors++; $display("FAIL stall_exec wena=%b want 1", rf_w_ena); end
        @(negedge clk);
        wait_halted(1, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL stall_halt halted=%b want 1", halted); end
        stall_mode = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        logic [31:0] rd;
        int lat;
        host_op(1'b1, 5'd1, 32'd1, rd, lat);
        host_op(1'b1, 5'd2, 32'd10, rd, lat);
        imem[0]    = mk(8'h20, 5'd2, 5'd1);
        imem[1]    = mk(8'h10, 5'd2, 5'd1);
        imem[8'h10] = mk(8'hFF, 5'd0, 5'd0);
        do_start();
        repeat (5) @(negedge clk);
        checks++;
        if (rf_w_ena !== 1'b1 || rf_w_addr !== 5'd2 || pc !== 8'h01 || insn_count !== 16'd1) begin
            errors++; $display("FAIL rst_pre_exec wena=%b addr=%h pc=%h cnt=%0d want 1/02/01/1", rf_w_ena, rf_w_addr, pc, insn_count);
        end
        rst = 1'b1;
        #1;
        checks++; if (rf_w_ena !== 1'b0) begin errors++; $display("FAIL rst_write_masked wena=%b want 0", rf_w_ena); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h00 || insn_count !== 16'd0) begin
            errors++; $display("FAIL rst_idle busy=%b halted=%b req=%b pc=%h cnt=%0d want 0/0/0/00/0", busy, halted, imem_req, pc, insn_count);
        end
        rst = 1'b0;
        @(negedge clk);
        host_op(1'b0, 5'd2, 32'd0, rd, lat);
        checks++; if (rd !== 32'd9) begin errors++; $display("FAIL rst_r2 got %h want 9", rd); end
    endtask

    task automatic test_host_arb();
        logic [31:0] rd;
        int lat;
        int halt_at, ack_at;
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        host_op(1'b1, 5'd2, 32'd7, rd, lat);
        host_op(1'b1, 5'd6, 32'd3, rd, lat);
        host_op(1'b1, 5'd4, 32'd10, rd, lat);
        host_op(1'b1, 5'd5, 32'd1, rd, lat);
        imem[0] = mk(8'h05, 5'd4, 5'd5);
        imem[1] = mk(8'hFF, 5'd2, 5'd6);
        imem[2] = mk(8'hFF, 5'd0, 5'd0);
        start = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 5'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || host_ack !== 1'b0) begin errors++; $display("FAIL arb_start_wins busy=%b ack=%b want 1/0", busy, host_ack); end
        halt_at = -1; ack_at = -1; rd = '0;
        for (int i = 1; i <= 100; i++) begin
            if (halted === 1'b1 && halt_at < 0) halt_at = i;
            if (host_ack === 1'b1) begin
                ack_at = i;
                rd = host_rdata;
                break;
            end
            @(negedge clk);
        end
        host_req = 1'b0; host_addr = '0;
        @(negedge clk);
        checks++; if (halt_at !== 10) begin errors++; $display("FAIL arb_halt_cycle got %0d want 10", halt_at); end
        checks++; if (ack_at !== 11) begin errors++; $display("FAIL arb_ack_cycle got %0d want 11", ack_at); end
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL arb_rdata got %h want 4", rd); end
    endtask

    task automatic test_random();
        logic [31:0] mr [32];
        logic [31:0] rd, v;
        logic [7:0]  mpc;
        logic [17:0] ins;
        int lat, n, len, mcnt;
        rand_wait_max = 3;
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < 32; r++) begin
                case ($urandom_range(0, 3))
                    0: v = 32'($urandom_range(0, 3));
                    1: v = 32'h8000_0000 + 32'($urandom_range(0, 3));
                    2: v = 32'h7FFF_FFFF;
                    default: v = $urandom;
                endcase
                mr[r] = v;
                host_op(1'b1, 5'(r), v, rd, lat);
                checks++; if (lat !== 1) begin errors++; $display("FAIL rnd%0d_wr_lat r%0d got %0d want 1", it, r, lat); end
            end
            for (int k = 0; k < 256; k++) imem[k] = 18'($urandom);
            len = $urandom_range(3, 12);
            for (int k = 0; k < len; k++) begin
                imem[k] = mk(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(k + 1, len)),
                             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
            imem[len] = mk(8'hFF, 5'd0, 5'd0);
            mpc = 8'h00; mcnt = 0;
            while (mpc != 8'hFF && mcnt < 100) begin
                ins = imem[mpc];
                mr[ins[9:5]] = mr[ins[9:5]] - mr[ins[4:0]];
                mcnt++;
                if (mr[ins[9:5]] == 32'd0 || mr[ins[9:5]][31]) mpc = ins[17:10];
                else mpc = mpc + 8'd1;
            end
            do_start();
            wait_halted(400, n);
            checks++;
            if (n < 0 || pc !== 8'hFF || insn_count !== 16'(mcnt)) begin
                errors++; $display("FAIL rnd%0d_end halted=%b pc=%h cnt=%0d want 1/ff/%0d", it, halted, pc, insn_count, mcnt);
            end
            for (int r = 0; r < 32; r++) begin
                host_op(1'b0, 5'(r), 32'd0, rd, lat);
                checks++;
                if (lat !== 1 || rd !== mr[r]) begin
                    errors++; $display("FAIL rnd%0d_r%0d got %h lat %0d want %h lat 1", it, r, rd, lat, mr[r]);
                end
            end
        end
        rand_wait_max = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) rf_mem[r] = '0;
        for (int k = 0; k < 256; k++) imem[k] = '0;
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_no_branch();
        test_halt();
        test_fetch_stall();
        test_reset_mid_exec();
        test_host_arb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
